imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Instruction-memory responder on the fetch side of the core.
- Accepts word-fetch requests issued from the PC (iaddr) over a valid/ready handshake.
- Reads a synchronous word-addressed instruction store with configurable wait states.
- Returns instruction words in request order through a small response FIFO, so fetch can stall without losing data.
- Supports a flush for branch/jump redirects.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the instruction store.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.
- WAIT_CYCLES, 0: extra cycles between request acceptance and data ready (0..15).
- FIFO_DEPTH, 2: response FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- rsp_valid  out  1  rsp_data/rsp_err valid.
- rsp_ready  in  1  fetch consumes the response.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  request was misaligned or out of range.
- flush  in  1  discard all in-flight and buffered requests (redirect).

Behaviour:
- Reset (rst=0, async):
  - State is IDLE and the FIFO is empty.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0.
  - The storage array is not reset.
- Handshakes:
  - A request transfers on the clk edge where req_valid && req_ready.
  - A response transfers on the edge where rsp_valid && rsp_ready.
  - rsp_data and rsp_err hold stable while rsp_valid=1 && rsp_ready=0.
- Word index is (req_addr-BASE_ADDR)>>2.
  - Error if req_addr[1:0]!=0, or if the index >= DEPTH_WORDS (unsigned compare, wrap-around counts as out of range).
  - An error response has rsp_err=1, rsp_data=32'h0000_0013 (NOP).
- FSM:
  - States: IDLE, WAIT, PUSH.
  - IDLE: on accept with WAIT_CYCLES=0, register the store read; the result enters the FIFO next edge. The FSM stays in IDLE, so throughput is 1 request/cycle.
  - IDLE: on accept with WAIT_CYCLES>0, go to WAIT and load the counter with WAIT_CYCLES.
  - WAIT: decrement the counter each cycle; at 0, go to PUSH.
  - PUSH: write the result into the FIFO, then go to IDLE.
- Latency:
  - Accepted at edge N means rsp_valid=1 after edge N+1+WAIT_CYCLES, provided the FIFO was empty.
  - The FIFO output is registered; there is no combinational req->rsp path.
- req_ready = rst && !flush && state==IDLE && (fifo_count + inflight) < FIFO_DEPTH.
  - No accepted request can ever find the FIFO full.
- Simultaneous push and pop on a full FIFO are both legal; the count is unchanged.
- Flush (sampled at the edge):
  - Empties the FIFO, aborts WAIT/PUSH and any registered read, and returns the FSM to IDLE.
  - rsp_valid=0 in the cycle after the flush edge.
  - A request presented in the same cycle as flush is not accepted (req_ready=0).
  - No response from a pre-flush request ever appears.
- Reset asserted mid-operation drops everything immediately, with the same effect as power-on reset.

Optional Feature:
IMEM_WR_PORT_EN
- Defined: adds ports wr_en (in, 1), wr_addr (in, 32), wr_data (in, 32) for program loading.
  - A write occurs at the edge when wr_en=1 and the address is aligned and in range; otherwise it is silently ignored.
  - A same-cycle read of the same word returns the old data (read-before-write).
- Undefined: no write ports exist; the store is initialised only by the memory-init file and is read-only.

Test Plan:
- WAIT_CYCLES=0, store[0]=32'h00500093, request addr 0x0 at edge N -> rsp_valid=1 after N+1, rsp_data=32'h00500093, rsp_err=0.
- WAIT_CYCLES=0, back-to-back addrs 0x0, 0x4, 0x8, rsp_ready=1 -> three responses in order on consecutive cycles; req_ready stays 1.
- rsp_ready=0, FIFO_DEPTH=2, WAIT_CYCLES=0: issue 3 requests -> req_ready drops to 0 after 2 accepted; rsp_data holds the first word; raising rsp_ready drains the responses in order.
- Request addr 0x2, then addr 0x1000 (DEPTH_WORDS=1024) -> two responses, both rsp_err=1, rsp_data=32'h00000013.
- WAIT_CYCLES=3: accept addr 0x4, assert flush 2 cycles later -> no response ever appears; req_ready=1 the cycle after the flush; a new request to addr 0x8 returns store[2].
- Assert rst=0 while the FIFO holds 2 entries -> rsp_valid=0 immediately (async); after release, FIFO empty and req_ready=1.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction store with wait states, in-order response FIFO and redirect flush.
// Define IMEM_WR_PORT_EN to add the wr_en/wr_addr/wr_data program-load port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
`ifdef IMEM_WR_PORT_EN
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
`endif
    input  logic        flush
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, PUSH} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic          fifo_err [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [PW+1:0] occupancy;
    logic [3:0]    cnt;
    logic [31:0]   res_data;
    logic          res_err, rd_valid, accept, push, pop, inflight;

    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= flush ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = (accept && WAIT_CYCLES != 0) ? WAIT : IDLE;
            WAIT: state_nx = (cnt == 4'd1) ? PUSH : WAIT;
            PUSH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pop in the same cycle frees a slot, so back-to-back fetches keep full throughput.
    always_comb begin
        inflight  = rd_valid || (state != IDLE);
        pop       = rsp_valid && rsp_ready;
        occupancy = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop);
        req_ready = rst && !flush && state == IDLE && occupancy < (PW+2)'(FIFO_DEPTH);
        accept    = req_valid && req_ready;
        push      = rd_valid || state == PUSH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            rd_valid <= accept && WAIT_CYCLES == 0;
            if (accept) begin
                res_data <= addr_bad(req_addr) ? NOP : mem[word_idx(req_addr)];
                res_err  <= addr_bad(req_addr);
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef IMEM_WR_PORT_EN
    // The read above samples the old word on a same-edge write.
    always_ff @(posedge clk) begin
        if (wr_en && !addr_bad(wr_addr)) mem[word_idx(wr_addr)] <= wr_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= res_data;
            fifo_err[wr_ptr]  <= res_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign rsp_valid = count != '0;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err   = rsp_valid && fifo_err[rd_ptr];
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: vector table plus scoreboard checks for two responder instances (0 and 3 wait states).
module tb_imem_responder;
    logic        clk, rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush;
    logic [31:0] req_addr, rsp_data;
    logic        req_valid_w, req_ready_w, rsp_valid_w, rsp_ready_w, rsp_err_w, flush_w;
    logic [31:0] req_addr_w, rsp_data_w;
    int          checks = 0, passes = 0;
    logic [32:0] q0[$], q3[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    imem_responder #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .flush(flush));

    imem_responder #(.WAIT_CYCLES(3)) dut_w (
        .clk(clk), .rst(rst), .req_valid(req_valid_w), .req_ready(req_ready_w), .req_addr(req_addr_w),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .rsp_data(rsp_data_w), .rsp_err(rsp_err_w), .flush(flush_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [31:0] i);
        return 32'h0050_0093 + (i << 20);
    endfunction

    function automatic logic [32:0] model(input logic [31:0] a);
        logic bad;
        bad = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
        return bad ? {1'b1, 32'h0000_0013} : {1'b0, word(a >> 2)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            q0.delete();
            q3.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb0 pending", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("sb0 data", rsp_data, e[31:0]);
                    chk("sb0 err", 32'(rsp_err), 32'(e[32]));
                end
            end
            if (req_valid && req_ready) q0.push_back(model(req_addr));
            if (flush_w) q3.delete();
            else begin
                if (rsp_valid_w && rsp_ready_w) begin
                    chk("sb3 pending", 32'(q3.size() != 0), 1);
                    if (q3.size() != 0) begin
                        e = q3.pop_front();
                        chk("sb3 data", rsp_data_w, e[31:0]);
                        chk("sb3 err", 32'(rsp_err_w), 32'(e[32]));
                    end
                end
                if (req_valid_w && req_ready_w) q3.push_back(model(req_addr_w));
            end
        end
    end

    initial begin
        vec_t tbl[8];
        int   n;
        tbl[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        tbl[1] = '{32'h0000_0004, 32'h0060_0093, 1'b0};
        tbl[2] = '{32'h0000_0008, 32'h0070_0093, 1'b0};
        tbl[3] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
        tbl[4] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
        tbl[5] = '{32'h0000_0FFC, 32'h4040_0093, 1'b0};
        tbl[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
        tbl[7] = '{32'h0000_0003, 32'h0000_0013, 1'b1};
        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
        req_valid_w = 1'b0; req_addr_w = '0; rsp_ready_w = 1'b0; flush_w = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut.mem[i] = word(32'(i));
            dut_w.mem[i] = word(32'(i));
        end
        #2;
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_err", 32'(rsp_err), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset req_ready_w", 32'(req_ready_w), 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("ready after reset", 32'(req_ready), 1);

        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = tbl[i].addr;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 1);
            tick();
            req_valid = 1'b0;
            chk($sformatf("vec%0d early valid", i), 32'(rsp_valid), 0);
            tick();
            chk($sformatf("vec%0d valid", i), 32'(rsp_valid), 1);
            chk($sformatf("vec%0d data", i), rsp_data, tbl[i].data);
            chk($sformatf("vec%0d err", i), 32'(rsp_err), 32'(tbl[i].err));
            tick();
            chk($sformatf("vec%0d drained", i), 32'(rsp_valid), 0);
        end

        req_valid = 1'b1; req_addr = 32'h0;
        #1 chk("b2b ready0", 32'(req_ready), 1);
        tick(); req_addr = 32'h4;
        #1 chk("b2b ready1", 32'(req_ready), 1);
        chk("b2b valid0", 32'(rsp_valid), 0);
        tick(); req_addr = 32'h8;
        #1 chk("b2b ready2", 32'(req_ready), 1);
        chk("b2b data0", rsp_data, 32'h0050_0093);
        tick(); req_valid = 1'b0;
        chk("b2b data1", rsp_data, 32'h0060_0093);
        tick();
        chk("b2b data2", rsp_data, 32'h0070_0093);
        tick();
        chk("b2b end valid", 32'(rsp_valid), 0);

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h10;
        #1 chk("stall ready0", 32'(req_ready), 1);
        tick(); req_addr = 32'h14;
        chk("stall ready1", 32'(req_ready), 1);
        tick(); req_addr = 32'h18;
        chk("stall ready drop", 32'(req_ready), 0);
        chk("stall data hold0", rsp_data, 32'h0090_0093);
        tick();
        chk("stall ready full", 32'(req_ready), 0);
        chk("stall data hold1", rsp_data, 32'h0090_0093);
        tick();
        chk("stall data hold2", rsp_data, 32'h0090_0093);
        req_valid = 1'b0; rsp_ready = 1'b1;
        #1 chk("stall ready on pop", 32'(req_ready), 1);
        tick();
        chk("stall drain1", rsp_data, 32'h00A0_0093);
        tick();
        chk("stall drained", 32'(rsp_valid), 0);

        rsp_ready_w = 1'b1;
        req_valid_w = 1'b1; req_addr_w = 32'h4;
        tick(); req_valid_w = 1'b0;
        chk("w3 ready busy", 32'(req_ready_w), 0);
        tick(); tick(); tick();
        chk("w3 not yet valid", 32'(rsp_valid_w), 0);
        tick();
        chk("w3 valid", 32'(rsp_valid_w), 1);
        chk("w3 data", rsp_data_w, 32'h0060_0093);
        tick();
        chk("w3 drained", 32'(rsp_valid_w), 0);

        req_valid_w = 1'b1; req_addr_w = 32'h4;
        tick(); req_valid_w = 1'b0;
        tick(); tick();
        flush_w = 1'b1; req_valid_w = 1'b1; req_addr_w = 32'h8;
        #1 chk("flush blocks req", 32'(req_ready_w), 0);
        tick();
        flush_w = 1'b0; req_valid_w = 1'b0;
        #1;
        chk("flush valid low", 32'(rsp_valid_w), 0);
        chk("flush ready after", 32'(req_ready_w), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush no stale rsp", 32'(rsp_valid_w), 0);
        end
        req_valid_w = 1'b1; req_addr_w = 32'h8;
        tick(); req_valid_w = 1'b0;
        n = 0;
        while (!rsp_valid_w && n < 20) begin
            tick();
            n++;
        end
        chk("post-flush valid", 32'(rsp_valid_w), 1);
        chk("post-flush data", rsp_data_w, 32'h0070_0093);
        chk("post-flush err", 32'(rsp_err_w), 0);
        tick();

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20;
        tick(); req_addr = 32'h24;
        tick(); req_valid = 1'b0;
        tick();
        chk("pre-reset valid", 32'(rsp_valid), 1);
        rst = 1'b0;
        #1;
        chk("async reset valid", 32'(rsp_valid), 0);
        chk("async reset data", rsp_data, 0);
        chk("async reset ready", 32'(req_ready), 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post reset valid", 32'(rsp_valid), 0);
        chk("post reset ready", 32'(req_ready), 1);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h8;
        tick(); req_valid = 1'b0;
        tick();
        chk("post reset data", rsp_data, 32'h0070_0093);
        tick(); tick();
        chk("sb0 drained", 32'(q0.size()), 0);
        chk("sb3 drained", 32'(q3.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
